// File: rtl/marquee_display_ctrl.sv
// Marquee animator for an N-digit multiplexed 7-segment display.
// Only one digit is lit per step, so no scan multiplexer is needed.
module marquee_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DVSR       = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  cw,
  input  logic [1:0]            mode,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            segment,
  output logic                  step
);

  localparam int PW = $clog2(2*NUM_DIGITS+4);
  localparam int CW = $clog2(DVSR);

  localparam logic [PW-1:0] NP       = PW'(NUM_DIGITS);
  localparam logic [PW-1:0] NP_M1    = PW'(NUM_DIGITS-1);
  localparam logic [PW-1:0] SN_C     = PW'(NUM_DIGITS+1);
  localparam logic [PW-1:0] SN_E     = PW'(2*NUM_DIGITS+2);
  localparam logic [PW-1:0] LAST_SQ  = PW'(2*NUM_DIGITS-1);
  localparam logic [PW-1:0] LAST_SN  = PW'(2*NUM_DIGITS+3);
  localparam logic [PW-1:0] TWO      = PW'(2);
  localparam logic [CW-1:0] PRE_LAST = CW'(DVSR-1);

  typedef enum logic [1:0] {SQUARE = 2'd0, SNAKE = 2'd1, BOUNCE = 2'd2, BLANK = 2'd3} mode_t;

  mode_t                  mode_reg;
  logic [CW-1:0]          prescaler;
  logic [PW-1:0]          pos;
  logic                   dir_down;

  logic                   mode_change;
  logic                   tick;
  logic [PW-1:0]          last;
  logic [PW-1:0]          pos_next;
  logic                   dir_next;
  logic [PW-1:0]          digit;
  logic [2:0]             seg_idx;
  logic [6:0]             seg7;
  logic                   lit;
  logic [NUM_DIGITS-1:0]  an_next;

  assign mode_change = (mode_t'(mode) != mode_reg);
  assign tick        = en && !mode_change && (prescaler == PRE_LAST);
  assign last        = (mode_reg == SNAKE) ? LAST_SN : LAST_SQ;

  always_comb begin
    pos_next = pos;
    dir_next = dir_down;
    case (mode_reg)
      SQUARE, SNAKE: begin
        if (cw) pos_next = (pos == last) ? '0 : pos + 1'b1;
        else    pos_next = (pos == '0) ? last : pos - 1'b1;
      end
      BOUNCE: begin
        // Reflect at either end instead of wrapping; cw has no effect here.
        if (!dir_down) begin
          if (pos == last) begin
            pos_next = last - 1'b1;
            dir_next = 1'b1;
          end else begin
            pos_next = pos + 1'b1;
          end
        end else begin
          if (pos == '0) begin
            pos_next = PW'(1);
            dir_next = 1'b0;
          end else begin
            pos_next = pos - 1'b1;
          end
        end
      end
      default: pos_next = '0;
    endcase
  end

  always_comb begin
    digit   = '0;
    seg_idx = 3'd0;
    seg7    = 7'h7F;
    lit     = 1'b1;
    case (mode_reg)
      SQUARE, BOUNCE: begin
        if (pos < NP) begin
          digit = NP_M1 - pos;
          seg7  = 7'b0100011;
        end else begin
          digit = pos - NP;
          seg7  = 7'b0011100;
        end
      end
      SNAKE: begin
        // Perimeter walk: a left-to-right, b/c on the rightmost digit, d right-to-left, e/f on the leftmost.
        if (pos < NP) begin
          digit   = NP_M1 - pos;
          seg_idx = 3'd0;
        end else if (pos == NP) begin
          seg_idx = 3'd1;
        end else if (pos == SN_C) begin
          seg_idx = 3'd2;
        end else if (pos < SN_E) begin
          digit   = pos - NP - TWO;
          seg_idx = 3'd3;
        end else if (pos == SN_E) begin
          digit   = NP_M1;
          seg_idx = 3'd4;
        end else begin
          digit   = NP_M1;
          seg_idx = 3'd5;
        end
        seg7 = ~(7'd1 << seg_idx);
      end
      default: lit = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_next[gi] = !(lit && (digit == PW'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg  <= SQUARE;
      prescaler <= '0;
      pos       <= '0;
      dir_down  <= 1'b0;
      an        <= '1;
      segment   <= 8'hFF;
      step      <= 1'b0;
    end else begin
      an      <= an_next;
      segment <= {1'b1, seg7};
      step    <= tick;
      if (mode_change) begin
        mode_reg  <= mode_t'(mode);
        pos       <= '0;
        prescaler <= '0;
        dir_down  <= 1'b0;
      end else if (en) begin
        if (prescaler == PRE_LAST) begin
          prescaler <= '0;
          pos       <= pos_next;
          dir_down  <= dir_next;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_marquee_display_ctrl.sv
// Bench for marquee_display_ctrl: per-cycle comparison against a positional model
// plus directed literal checks of the animation sequences.
module tb_marquee_display_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b1;
  logic         cw = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] an;
  logic [7:0]   segment;
  logic         step;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  marquee_display_ctrl #(.NUM_DIGITS(N), .DVSR(D)) dut (
    .clk(clk), .reset(reset), .en(en), .cw(cw), .mode(mode),
    .an(an), .segment(segment), .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected anode/segment pattern for a position, straight from the path description.
  function automatic logic [N+7:0] decode(input int p, input int md);
    int dig;
    int idx;
    logic [6:0]   s;
    logic [N-1:0] a;
    if (md == 3) return {{N{1'b1}}, 8'hFF};
    if (md == 1) begin
      if (p < N)            begin dig = N-1-p;   idx = 0; end
      else if (p == N)      begin dig = 0;       idx = 1; end
      else if (p == N+1)    begin dig = 0;       idx = 2; end
      else if (p <= 2*N+1)  begin dig = p-N-2;   idx = 3; end
      else if (p == 2*N+2)  begin dig = N-1;     idx = 4; end
      else                  begin dig = N-1;     idx = 5; end
      s = 7'h7F;
      s[idx] = 1'b0;
    end else begin
      if (p < N) begin dig = N-1-p; s = 7'b0100011; end
      else       begin dig = p-N;   s = 7'b0011100; end
    end
    a = '1;
    a[dig] = 1'b0;
    return {a, 1'b1, s};
  endfunction

  int           m_pos, m_cnt, m_mode, m_len;
  bit           m_down;
  logic [N-1:0] e_an;
  logic [7:0]   e_seg;
  logic         e_step;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pos = 0; m_cnt = 0; m_mode = 0; m_down = 0;
        e_an = '1; e_seg = 8'hFF; e_step = 1'b0;
      end else begin
        {e_an, e_seg} = decode(m_pos, m_mode);
        e_step = 1'b0;
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode); m_pos = 0; m_cnt = 0; m_down = 0;
        end else if (en) begin
          m_cnt++;
          if (m_cnt == D) begin
            m_cnt  = 0;
            e_step = 1'b1;
            m_len  = (m_mode == 1) ? 2*N+4 : 2*N;
            if (m_mode == 3) m_pos = 0;
            else if (m_mode == 2) begin
              if (!m_down) begin
                if (m_pos == m_len-1) begin m_down = 1; m_pos = m_len-2; end
                else m_pos++;
              end else begin
                if (m_pos == 0) begin m_down = 0; m_pos = 1; end
                else m_pos--;
              end
            end else m_pos = cw ? (m_pos+1) % m_len : (m_pos+m_len-1) % m_len;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_an", an, e_an);
        check("cyc_seg", segment, e_seg);
        check("cyc_step", step, e_step);
      end
    end
  end

  task automatic wait_step(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step && cyc < budget);
    if (!step) check("step_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] sq_an  [8] = '{4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0111};
  logic [7:0] sq_seg [8] = '{8'hA3, 8'hA3, 8'hA3, 8'h9C, 8'h9C, 8'h9C, 8'h9C, 8'hA3};
  logic [3:0] sn_an  [12] = '{4'b1011, 4'b1101, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
                              4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
  logic [7:0] sn_seg [12] = '{8'hFE, 8'hFE, 8'hFE, 8'hFD, 8'hFB, 8'hF7,
                              8'hF7, 8'hF7, 8'hF7, 8'hEF, 8'hDF, 8'hFE};

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", segment, 8'hFF);
    check("rst_step", step, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("sq_pos0_an", an, 4'b0111);
    check("sq_pos0_seg", segment, 8'hA3);

    // Square, clockwise, through one full wrap.
    for (int i = 0; i < 8; i++) begin
      wait_step(20, cyc);
      check("sq_period", cyc, 3);
      @(negedge clk);
      check("sq_an", an, sq_an[i]);
      check("sq_seg", segment, sq_seg[i]);
    end

    // Square, counter-clockwise from reset.
    reset = 1'b1;
    cw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_step(20, cyc);
    check("ccw_first_lat", cyc, 4);
    @(negedge clk);
    check("ccw_pos7_an", an, 4'b0111);
    check("ccw_pos7_seg", segment, 8'h9C);
    wait_step(20, cyc);
    @(negedge clk);
    check("ccw_pos6_an", an, 4'b1011);
    check("ccw_pos6_seg", segment, 8'h9C);

    // Snake, full lap plus wrap.
    cw = 1'b1;
    mode = 2'd1;
    for (int i = 0; i < 12; i++) begin
      wait_step(20, cyc);
      @(negedge clk);
      check("sn_an", an, sn_an[i]);
      check("sn_seg", segment, sn_seg[i]);
    end

    // Bounce: cw toggled mid-run must not alter the sequence.
    mode = 2'd2;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) cw = 1'b0;
      if (i == 10) cw = 1'b1;
      wait_step(20, cyc);
      @(negedge clk);
      if (i == 6)  begin check("bn_pos7_an", an, 4'b0111); check("bn_pos7_seg", segment, 8'h9C); end
      if (i == 7)  begin check("bn_pos6_an", an, 4'b1011); check("bn_pos6_seg", segment, 8'h9C); end
      if (i == 13) begin check("bn_pos0_an", an, 4'b0111); check("bn_pos0_seg", segment, 8'hA3); end
      if (i == 14) begin check("bn_pos1_an", an, 4'b1011); check("bn_pos1_seg", segment, 8'hA3); end
    end

    // Enable freeze with prescaler at 2.
    mode = 2'd0;
    wait_step(20, cyc);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("frz_step", step, 1'b0);
      check("frz_an", an, 4'b1011);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume_step1", step, 1'b0);
    @(negedge clk);
    check("resume_step2", step, 1'b1);

    // Mode change from square at pos 5 to snake.
    repeat (3) wait_step(20, cyc);
    mode = 2'd1;
    @(negedge clk);
    check("mchg_old_an", an, 4'b1101);
    check("mchg_old_seg", segment, 8'h9C);
    @(negedge clk);
    check("mchg_new_an", an, 4'b0111);
    check("mchg_new_seg", segment, 8'hFE);
    wait_step(20, cyc);
    check("mchg_period", cyc, 3);

    // Blank mode.
    mode = 2'd3;
    repeat (2) @(negedge clk);
    check("blank_an", an, 4'b1111);
    check("blank_seg", segment, 8'hFF);

    // Asynchronous reset mid-run.
    mode = 2'd0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_an", an, 4'b1111);
    check("arst_seg", segment, 8'hFF);
    check("arst_step", step, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_step(20, cyc);
    check("arst_restart", cyc, 4);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
